// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - ALU/LSU register-file write-port arbiter with pending-write scoreboard
module regfile_write_arbiter #(
    parameter int REGISTER_WIDTH_LENGTH = 32,
    parameter int ADDRESS_WIDTH_LENGTH  = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    AluValid,
    input  logic [ADDRESS_WIDTH_LENGTH-1:0]         AluReg,
    input  logic [REGISTER_WIDTH_LENGTH-1:0]        AluData,
    output logic                                    AluReady,
    input  logic                                    LsuValid,
    input  logic [ADDRESS_WIDTH_LENGTH-1:0]         LsuReg,
    input  logic [REGISTER_WIDTH_LENGTH-1:0]        LsuData,
    output logic                                    LsuReady,
    input  logic                                    IssueValid,
    input  logic [ADDRESS_WIDTH_LENGTH-1:0]         IssueReg,
    output logic [(1<<ADDRESS_WIDTH_LENGTH)-1:0]    Busy,
    output logic                                    RegWrite,
    output logic [ADDRESS_WIDTH_LENGTH-1:0]         WriteReg,
    output logic [REGISTER_WIDTH_LENGTH-1:0]        WriteData
);

    localparam int NUM_REGS = 1 << ADDRESS_WIDTH_LENGTH;

    // last_grant remembers who won the most recent handshake; the other side wins the next tie
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    logic                             last_grant;
    logic                             alu_accept;
    logic                             lsu_accept;
    logic [ADDRESS_WIDTH_LENGTH-1:0]  sel_reg;
    logic [REGISTER_WIDTH_LENGTH-1:0] sel_data;
    logic [NUM_REGS-1:0]              busy_next;

    // Grant selection: lone requester wins, ties go round-robin, nothing granted during reset
    always_comb begin
        AluReady = 1'b0;
        LsuReady = 1'b0;
        if (!rst) begin
            if (AluValid && LsuValid) begin
                if (last_grant == GRANT_LSU) begin
                    AluReady = 1'b1;
                end else begin
                    LsuReady = 1'b1;
                end
            end else begin
                AluReady = AluValid;
                LsuReady = LsuValid;
            end
        end
    end

    assign alu_accept = AluValid & AluReady;
    assign lsu_accept = LsuValid & LsuReady;
    assign sel_reg    = alu_accept ? AluReg  : LsuReg;
    assign sel_data   = alu_accept ? AluData : LsuData;

    // Register the accepted request onto the write port; x0 is consumed but never written
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_LSU;
            RegWrite   <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (alu_accept || lsu_accept) begin
                last_grant <= alu_accept ? GRANT_ALU : GRANT_LSU;
                RegWrite   <= (sel_reg != '0);
                WriteReg   <= sel_reg;
                WriteData  <= sel_data;
            end
        end
    end

    // Scoreboard update: clear on writeback first, then a new issue to the same register re-sets it
    always_comb begin
        busy_next = Busy;
        if (RegWrite) begin
            busy_next[WriteReg] = 1'b0;
        end
        if (IssueValid && (IssueReg != '0)) begin
            busy_next[IssueReg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state; reset wipes every pending mark
    always_ff @(posedge clk) begin
        if (rst) begin
            Busy <= '0;
        end else begin
            Busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard testbench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        AluValid, LsuValid, IssueValid;
    logic [4:0]  AluReg, LsuReg, IssueReg;
    logic [31:0] AluData, LsuData;
    logic        AluReady, LsuReady;
    logic [31:0] Busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    regfile_write_arbiter #(
        .REGISTER_WIDTH_LENGTH(32),
        .ADDRESS_WIDTH_LENGTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .AluValid  (AluValid),
        .AluReg    (AluReg),
        .AluData   (AluData),
        .AluReady  (AluReady),
        .LsuValid  (LsuValid),
        .LsuReg    (LsuReg),
        .LsuData   (LsuData),
        .LsuReady  (LsuReady),
        .IssueValid(IssueValid),
        .IssueReg  (IssueReg),
        .Busy      (Busy),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; readies are checked and expected writes queued at the negedge
    task automatic drive(input string name, input logic rs,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ir,
                         input logic ea, input logic el);
        wr_t e;
        @(posedge clk);
        #1;
        rst = rs;
        AluValid = av; AluReg = ar; AluData = ad;
        LsuValid = lv; LsuReg = lr; LsuData = ld;
        IssueValid = iv; IssueReg = ir;
        @(negedge clk);
        check({name, " AluReady"}, {63'd0, AluReady}, {63'd0, ea});
        check({name, " LsuReady"}, {63'd0, LsuReady}, {63'd0, el});
        if (ea && ar != 5'd0) begin
            e.cyc = cyc + 1; e.r = ar; e.d = ad;
            sb.push_back(e);
        end
        if (el && lr != 5'd0) begin
            e.cyc = cyc + 1; e.r = lr; e.d = ld;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input string name);
        drive(name, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic issue(input string name, input logic [4:0] r);
        drive(name, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, r, 1'b0, 1'b0);
    endtask

    task automatic alu(input string name, input logic [4:0] r, input logic [31:0] d);
        drive(name, 1'b0, 1'b1, r, d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle RegWrite must match the scoreboard head, and a write must carry its entry
    initial begin
        wr_t e;
        logic exp_w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_w = (sb.size() > 0) && (sb[0].cyc == cyc);
                check("RegWrite", {63'd0, RegWrite}, {63'd0, exp_w});
                if (exp_w) begin
                    e = sb.pop_front();
                    check("WriteReg", {59'd0, WriteReg}, {59'd0, e.r});
                    check("WriteData", {32'd0, WriteData}, {32'd0, e.d});
                end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    check("missed write", {59'd0, e.r}, 64'hFFFF);
                end
            end
        end
    end

    initial begin
        int ai;
        int li;
        logic ga;
        rst = 1'b1;
        AluValid = 1'b0; AluReg = '0; AluData = '0;
        LsuValid = 1'b0; LsuReg = '0; LsuData = '0;
        IssueValid = 1'b0; IssueReg = '0;
        @(posedge clk);
        mon_en = 1'b1;

        // Reset: requests and issues ignored while rst is high
        drive("rst hold", 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 1'b0, 1'b0);
        idle("post rst");
        check("rst WriteReg", {59'd0, WriteReg}, 64'd0);
        check("rst WriteData", {32'd0, WriteData}, 64'd0);
        check("rst Busy", {32'd0, Busy}, 64'd0);

        // Tie right after reset: ALU first, then LSU
        drive("tie1", 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 1'b0);
        drive("tie2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 1'b1);
        idle("tie3");
        idle("tie4");

        // Sustained contention: alternate ALU, LSU, ... with loser holding its request
        ai = 0; li = 0;
        for (int k = 0; k < 6; k++) begin
            ga = (k % 2 == 0);
            drive("contend", 1'b0, 1'b1, 5'(10 + ai), 32'hA0 + 32'(ai),
                  1'b1, 5'(20 + li), 32'hB0 + 32'(li), 1'b0, 5'd0, ga, !ga);
            if (ga) ai++; else li++;
        end
        idle("contend end");

        // Single ALU write and hold of the write port afterwards
        alu("alu5", 5'd5, 32'hDEADBEEF);
        idle("alu5 wb");
        idle("alu5 hold");
        check("hold WriteReg", {59'd0, WriteReg}, 64'd5);
        check("hold WriteData", {32'd0, WriteData}, 64'hDEADBEEF);

        // x0 write consumed without RegWrite, and it still moves the round-robin pointer
        drive("x0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 1'b0, 1'b1);
        idle("x0 wb");
        check("x0 Busy", {32'd0, Busy}, 64'd0);
        drive("tie after x0", 1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 1'b0);
        drive("lsu after x0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 1'b1);
        idle("gap");

        // Scoreboard set, clear, same-register re-set, different-register set, x0 issue
        issue("issue7", 5'd7);
        alu("alu7a", 5'd7, 32'h77);
        check("busy7 set", {32'd0, Busy}, 64'h80);
        idle("alu7a wb");
        idle("alu7a after");
        check("busy7 clear", {32'd0, Busy}, 64'h0);
        alu("alu7b", 5'd7, 32'h78);
        issue("reissue7", 5'd7);
        idle("reissue7 after");
        check("busy7 rewin", {32'd0, Busy}, 64'h80);
        alu("alu7c", 5'd7, 32'h79);
        issue("issue12", 5'd12);
        idle("issue12 after");
        check("busy set/clear diff", {32'd0, Busy}, 64'h1000);
        issue("issue0", 5'd0);
        idle("issue0 after");
        check("busy issue0", {32'd0, Busy}, 64'h1000);

        // Reset mid-operation
        issue("issue10", 5'd10);
        alu("alu3", 5'd3, 32'h33);
        drive("rst mid", 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88, 1'b1, 5'd15, 1'b0, 1'b0);
        idle("rst mid after");
        check("rst2 WriteReg", {59'd0, WriteReg}, 64'd0);
        check("rst2 WriteData", {32'd0, WriteData}, 64'd0);
        check("rst2 Busy", {32'd0, Busy}, 64'd0);
        drive("tie after rst", 1'b0, 1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 1'b1, 1'b0);
        drive("lsu after rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 1'b0, 1'b1);
        idle("drain1");
        idle("drain2");
        idle("drain3");

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
